// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, predecode opcodes and the
// fetch-queue entry layout.
package cpu_pkg;

    localparam int unsigned WORD      = 64;
    localparam int unsigned INSTR_LEN = 32;

    // B: bits [31:26]; CBZ: bits [31:24]
    localparam logic [5:0] OPC_B   = 6'b000101;
    localparam logic [7:0] OPC_CBZ = 8'b10110100;

    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/instr_predecode.sv
// Lightweight branch classifier: flags B as unconditional and CBZ as
// conditional without a full decode. Shared with the hazard unit.
module instr_predecode
    import cpu_pkg::*;
(
    input  logic [INSTR_LEN-1:0] instr,
    output logic                 is_uncond,
    output logic                 is_cond
);

    // Opcode match on the top instruction bits
    always_comb begin
        is_uncond = (instr[INSTR_LEN-1 -: 6] == OPC_B);
        is_cond   = (instr[INSTR_LEN-1 -: 8] == OPC_CBZ);
    end

endmodule

// File: rtl/fetch_queue.sv
// Valid/ready instruction buffer between fetch and decode. Holds
// {pc, instruction} pairs, presents the head show-ahead with predecode
// flags, and empties on a branch redirect (flush).
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = WORD,
    parameter int unsigned INSTR_W = INSTR_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic                       out_is_uncond,
    output logic                       out_is_cond,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head_instr;
    logic               dec_uncond;
    logic               dec_cond;

    // Handshake qualification; flush suppresses both transfers
    always_comb begin
        in_ready  = (count_q < CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers and occupancy; flush takes priority over push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Show-ahead head, forced to zero while empty
    always_comb begin
        out_pc     = '0;
        head_instr = '0;
        if (out_valid) begin
            out_pc     = pc_mem[rd_ptr];
            head_instr = instr_mem[rd_ptr];
        end
        out_instr     = head_instr;
        out_is_uncond = out_valid && dec_uncond;
        out_is_cond   = out_valid && dec_cond;
        count         = count_q;
    end

    instr_predecode u_predecode (
        .instr     (head_instr),
        .is_uncond (dec_uncond),
        .is_cond   (dec_cond)
    );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction buffer between iFetch and iDecode. Replaces the direct instruction/cur_pc wiring with a valid/ready FIFO of {pc, instruction} pairs.
- Lets fetch run ahead of a stalled decode stage.
- Discards all buffered entries on a branch redirect (flush).
- Predecodes the head entry so later stages can detect branches without a full decode: B flags as unconditional, CBZ as conditional.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PC_W, 64, pc width (matches `WORD)
- INSTR_W, 32, instruction width (matches `INSTR_LEN)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  branch redirect; empties the queue at the next edge
- in_valid  in  1  fetch presents an entry
- in_pc  in  PC_W  pc of the entry
- in_instr  in  INSTR_W  instruction of the entry
- in_ready  out  1  queue can accept an entry
- out_valid  out  1  head entry valid
- out_pc  out  PC_W  head pc
- out_instr  out  INSTR_W  head instruction
- out_is_uncond  out  1  head is B (instr[31:26]==6'b000101)
- out_is_cond  out  1  head is CBZ (instr[31:24]==8'b10110100)
- out_ready  in  1  decode consumes the head
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset low, asynchronous):
  - write pointer, read pointer and count go to 0 immediately.
  - out_valid=0, in_ready=1, count=0.
  - Storage contents are not cleared.
- Push: in_valid && in_ready at a rising edge writes {in_pc, in_instr} at the write pointer. Write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge increments the read pointer modulo DEPTH.
- in_ready = (count < DEPTH). It is combinational from registered count only, with no dependence on out_ready, so there is no full-bypass.
- out_valid = (count != 0). Show-ahead head: out_pc/out_instr/predecode flags are combinational from storage at the read pointer.
- When empty, out_pc, out_instr, out_is_uncond and out_is_cond are all driven 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N; consume no earlier than edge N+1.
- Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
- Full: in_ready=0 and in_valid is ignored, even if a pop occurs in the same cycle.
- Empty: out_ready is ignored and count stays at 0.
- Wrap-around: pointers are $clog2(DEPTH) bits and roll over naturally. Order is strictly FIFO across the wrap.
- Flush has priority over push and pop in the same cycle:
  - both pointers and count go to 0 at the edge;
  - any concurrent push and pop is dropped;
  - in the cycle after the flush edge: out_valid=0, in_ready=1.
- Reset asserted mid-operation discards all entries asynchronously. Operation resumes on the first rising edge after reset is deasserted.
- count never exceeds DEPTH and never underflows. The bench asserts this on every edge.

Decomposition:
- Shared package cpu_pkg:
  - constants WORD=64 and INSTR_LEN=32;
  - OPC_B=6'b000101 and OPC_CBZ=8'b10110100;
  - typedef fq_entry_t as a packed struct {pc, instr}.
- Sub-module instr_predecode: combinational, maps an instruction to is_uncond/is_cond. It is reused later by the hazard unit.
- FIFO storage, pointers and control stay in fetch_queue.

Test Plan:
- Reset, then push pc=0/F84402C9, pc=4/8B09026A, pc=8/CB0A028B with out_ready=0 -> count=3. Head then shows pc=0, F84402C9 with both flags 0.
- Set out_ready=1 and continue pushing -> pops occur in order 0, 4, 8.
- Fill 4 entries -> in_ready=0 and count=4. A further push of pc=16/F80602CB is rejected.
- Pop once, then push pc=16 -> the write wraps and pc=16 exits last.
- Simultaneous push and pop at count=2 -> count stays 2 and order is preserved.
- Push pc=16/B4FFFF6B (CBZ X11,-5) and pc=20/14000010 (B 64):
  - out_is_cond=1 at pc=16;
  - out_is_uncond=1 at pc=20.
- With count=3, assert flush together with in_valid and out_ready -> count=0 and out_valid=0 next cycle. The flushed-cycle push does not appear.
- Assert reset low mid-cycle with count=2 -> out_valid=0 and count=0 before the next edge. After release, a push of pc=40 is the first output.
